// File: rtl/mem_access_unit.sv
// Load/store front end for the single-port data RAM: turns one-shot byte/half/word requests into RAM cycles.
// Sub-word support is compiled in with `define MEM_ACCESS_SUBWORD_EN; otherwise only aligned words are legal.
module mem_access_unit #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  signed_ld,
    input  logic [ADDR_WIDTH+1:0] byte_addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_data_in,
    output logic                  ram_wr_en,
    input  logic [31:0]           ram_data_out
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WR   = 2'b10;

    logic [1:0]  state;
    logic        op_we;
    logic [31:0] op_wdata;
    logic        legal;
    logic [31:0] ld_data;
    logic [31:0] st_data;

`ifdef MEM_ACCESS_SUBWORD_EN
    logic [1:0]  op_size;
    logic        op_signed;
    logic [1:0]  op_lane;
    logic [31:0] hold;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        legal = 1'b0;
        case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~byte_addr[0];
            2'b10:   legal = (byte_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        ld_byte = ram_data_out[{op_lane, 3'b000} +: 8];
        ld_half = op_lane[1] ? ram_data_out[31:16] : ram_data_out[15:0];
        ld_data = ram_data_out;
        case (op_size)
            2'b00:   ld_data = {{24{op_signed & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{op_signed & ld_half[15]}}, ld_half};
            default: ld_data = ram_data_out;
        endcase
    end

    // Sub-word stores splice the new lane(s) into the word read back in RD.
    always_comb begin
        st_data = op_wdata;
        if (op_size == 2'b00) begin
            st_data = hold;
            st_data[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
        end else if (op_size == 2'b01) begin
            st_data = hold;
            if (op_lane[1])
                st_data[31:16] = op_wdata[15:0];
            else
                st_data[15:0] = op_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_size   <= 2'b00;
            op_signed <= 1'b0;
            op_lane   <= 2'b00;
            hold      <= 32'h0;
        end else begin
            if (state == IDLE && req && legal) begin
                op_size   <= size;
                op_signed <= signed_ld;
                op_lane   <= byte_addr[1:0];
            end
            if (state == RD)
                hold <= ram_data_out;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = signed_ld;
    assign legal      = (size == 2'b10) && (byte_addr[1:0] == 2'b00);
    assign ld_data    = ram_data_out;
    assign st_data    = op_wdata;
`endif

    assign busy        = (state != IDLE);
    assign ram_wr_en   = (state == WR);
    assign ram_data_in = (state == WR) ? st_data : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'h0;
            ram_addr <= '0;
            op_we    <= 1'b0;
            op_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!legal) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            op_we    <= we;
                            op_wdata <= wdata;
                            ram_addr <= byte_addr[ADDR_WIDTH+1:2];
                            // Only word stores skip the read; sub-word stores need the old word.
                            state    <= (we && size == 2'b10) ? WR : RD;
                        end
                    end
                end
                RD: begin
                    if (op_we) begin
                        state <= WR;
                    end else begin
                        rdata <= ld_data;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                WR: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural RAM, scoreboard of expected done/err/rdata,
// and scenario tasks for reset, word, sub-word, error, back-to-back and reset-during-write cases.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          signed_ld = 1'b0;
    logic [AW+1:0] byte_addr = '0;
    logic [31:0]   wdata = 32'h0;
    logic          busy, done, err;
    logic [31:0]   rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data_in;
    logic          ram_wr_en;
    logic [31:0]   ram_data_out;

    logic [31:0]   mem [DEPTH];
    exp_t          sb[$];
    int            cyc = 0;
    int            total = 0;
    int            passed = 0;
    int            wr_at;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy_bad;
    logic [31:0]   rd_model = 32'h0;

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .signed_ld(signed_ld),
        .byte_addr(byte_addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_wr_en(ram_wr_en),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= ram_data_in;
    assign ram_data_out = mem[ram_addr];

    // Scoreboard: every done pulse retires the oldest outstanding request.
    exp_t mx;
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                mx = sb.pop_front();
                total++;
                if (cyc !== mx.due) $display("FAIL %s_latency: done at cycle %0d, required %0d", mx.name, cyc, mx.due);
                else passed++;
                total++;
                if (err !== mx.err) $display("FAIL %s_err: err=%b, required %b", mx.name, err, mx.err);
                else passed++;
                total++;
                if (rdata !== mx.rdata) $display("FAIL %s_rdata: rdata=%h, required %h", mx.name, rdata, mx.rdata);
                else passed++;
                total++;
                if (busy !== 1'b0) $display("FAIL %s_busy_at_done: busy=%b, required 0", mx.name, busy);
                else passed++;
            end
        end
    end

    // Called at a negedge; drives one request and follows it until done, recording RAM activity.
    task automatic run_op(input string name, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [AW+1:0] a, input logic [31:0] d, input int lat, input logic e);
        exp_t x;
        bit   seen;
        seen = 0;
        x.due = cyc + lat; x.err = e; x.rdata = rd_model; x.name = name;
        sb.push_back(x);
        req = 1'b1; we = w; size = sz; signed_ld = sg; byte_addr = a; wdata = d;
        wr_at = 0; wr_addr = '0; wr_data = 32'h0; busy_bad = 1'b0;
        for (int n = 1; n <= 8 && !seen; n++) begin
            @(negedge clk);
            if (ram_wr_en === 1'b1 && wr_at == 0) begin
                wr_at = n; wr_addr = ram_addr; wr_data = ram_data_in;
            end
            if (done === 1'b1) seen = 1;
            else if (busy !== 1'b1) busy_bad = 1'b1;
            if (n == 1) begin
                req = 1'b0; we = ~w; size = ~sz; signed_ld = ~sg; byte_addr = a ^ 4; wdata = ~d;
            end
        end
        if (!seen) begin
            total++;
            $display("FAIL %s_timeout: no done within 8 cycles, required done after %0d", name, lat);
            x = sb.pop_back();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; byte_addr = 10'h010; wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %b, required 0", err); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", rdata); else passed++;
        total++; if (ram_addr !== '0) $display("FAIL reset_ram_addr: got %h, required 0", ram_addr); else passed++;
        total++; if (ram_data_in !== 32'h0) $display("FAIL reset_ram_data_in: got %h, required 0", ram_data_in); else passed++;
        total++; if (ram_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b, required 0", ram_wr_en); else passed++;
        reset = 1'b0; req = 1'b0;
        busy_bad = 1'b0; wr_at = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_bad = 1'b1;
            if (ram_wr_en !== 1'b0) wr_at = 1;
        end
        total++; if (busy_bad !== 1'b0) $display("FAIL idle_busy: busy rose=%b, required 0", busy_bad); else passed++;
        total++; if (wr_at != 0) $display("FAIL idle_wr_en: wr_en rose=%0d, required 0", wr_at); else passed++;
    endtask

    task automatic test_word();
        run_op("sw", 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEAD_BEEF, 2, 1'b0);
        total++; if (wr_at != 1) $display("FAIL sw_wr_cycle: write in T+%0d, required T+1", wr_at); else passed++;
        total++; if (wr_addr !== 8'd4) $display("FAIL sw_wr_addr: got %h, required 04", wr_addr); else passed++;
        total++; if (wr_data !== 32'hDEAD_BEEF) $display("FAIL sw_wr_data: got %h, required deadbeef", wr_data); else passed++;
        total++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL sw_mem: word4=%h, required deadbeef", mem[4]); else passed++;
        total++; if (busy_bad !== 1'b0) $display("FAIL sw_busy: busy dropped early=%b, required 0", busy_bad); else passed++;
        rd_model = 32'hDEAD_BEEF;
        run_op("lw", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 2, 1'b0);
        total++; if (wr_at != 0) $display("FAIL lw_wr_en: write in T+%0d, required none", wr_at); else passed++;
    endtask

    task automatic test_subword();
        mem[4] = 32'h1122_3344;
`ifdef MEM_ACCESS_SUBWORD_EN
        run_op("sb", 1'b1, 2'b00, 1'b0, 10'h011, 32'h1234_56A5, 3, 1'b0);
        total++; if (wr_at != 2) $display("FAIL sb_wr_cycle: write in T+%0d, required T+2", wr_at); else passed++;
        total++; if (mem[4] !== 32'h1122_A544) $display("FAIL sb_mem: word4=%h, required 1122a544", mem[4]); else passed++;
        rd_model = 32'hFFFF_FFA5;
        run_op("lb", 1'b0, 2'b00, 1'b1, 10'h011, 32'h0, 2, 1'b0);
        rd_model = 32'h0000_00A5;
        run_op("lbu", 1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 2, 1'b0);
        run_op("sh", 1'b1, 2'b01, 1'b0, 10'h012, 32'hABCD_8001, 3, 1'b0);
        total++; if (mem[4] !== 32'h8001_A544) $display("FAIL sh_mem: word4=%h, required 8001a544", mem[4]); else passed++;
        rd_model = 32'hFFFF_8001;
        run_op("lh", 1'b0, 2'b01, 1'b1, 10'h012, 32'h0, 2, 1'b0);
        rd_model = 32'h0000_8001;
        run_op("lhu", 1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 2, 1'b0);
        rd_model = 32'hFFFF_FF80;
        run_op("lb_lane3", 1'b0, 2'b00, 1'b1, 10'h013, 32'h0, 2, 1'b0);
        rd_model = 32'h0000_A544;
        run_op("lhu_lane0", 1'b0, 2'b01, 1'b0, 10'h010, 32'h0, 2, 1'b0);
`else
        run_op("sb_off", 1'b1, 2'b00, 1'b0, 10'h010, 32'h0000_00A5, 1, 1'b1);
        total++; if (wr_at != 0) $display("FAIL sb_off_wr_en: write in T+%0d, required none", wr_at); else passed++;
        run_op("lb_off", 1'b0, 2'b00, 1'b1, 10'h010, 32'h0, 1, 1'b1);
        run_op("lh_off", 1'b0, 2'b01, 1'b0, 10'h010, 32'h0, 1, 1'b1);
        total++; if (mem[4] !== 32'h1122_3344) $display("FAIL sub_off_mem: word4=%h, required 11223344", mem[4]); else passed++;
`endif
    endtask

    task automatic test_errors();
        mem[4] = 32'h0BAD_F00D;
        run_op("lw_misalign", 1'b0, 2'b10, 1'b0, 10'h013, 32'h0, 1, 1'b1);
        run_op("sh_misalign", 1'b1, 2'b01, 1'b0, 10'h011, 32'h0000_FFFF, 1, 1'b1);
        total++; if (wr_at != 0) $display("FAIL sh_misalign_wr_en: write in T+%0d, required none", wr_at); else passed++;
        run_op("size11_st", 1'b1, 2'b11, 1'b0, 10'h010, 32'h5555_5555, 1, 1'b1);
        total++; if (wr_at != 0) $display("FAIL size11_wr_en: write in T+%0d, required none", wr_at); else passed++;
        run_op("size11_ld", 1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 1, 1'b1);
        total++; if (mem[4] !== 32'h0BAD_F00D) $display("FAIL err_mem: word4=%h, required 0badf00d", mem[4]); else passed++;
    endtask

    task automatic test_back_to_back();
        int start;
        int budget;
        start = cyc;
        budget = 0;
        run_op("b2b_sw", 1'b1, 2'b10, 1'b0, 10'h020, 32'h55AA_55AA, 2, 1'b0); budget += 2;
        rd_model = 32'h55AA_55AA;
        run_op("b2b_lw", 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 2, 1'b0); budget += 2;
        run_op("b2b_err", 1'b0, 2'b10, 1'b0, 10'h022, 32'h0, 1, 1'b1); budget += 1;
`ifdef MEM_ACCESS_SUBWORD_EN
        run_op("b2b_sb", 1'b1, 2'b00, 1'b0, 10'h021, 32'h0000_0033, 3, 1'b0); budget += 3;
        rd_model = 32'h0000_0033;
        run_op("b2b_lbu", 1'b0, 2'b00, 1'b0, 10'h021, 32'h0, 2, 1'b0); budget += 2;
        total++; if (mem[8] !== 32'h55AA_33AA) $display("FAIL b2b_mem: word8=%h, required 55aa33aa", mem[8]); else passed++;
`endif
        rd_model = 32'h55AA_55AA;
        run_op("b2b_lw2", 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 2, 1'b0); budget += 2;
        total++; if (cyc - start != budget) $display("FAIL b2b_cycles: took %0d, required %0d", cyc - start, budget); else passed++;
    endtask

    task automatic test_reset_mid_wr();
        bit late_done;
        mem[8] = 32'hCAFE_F00D;
        req = 1'b1; we = 1'b1; signed_ld = 1'b0; byte_addr = 10'h020;
`ifdef MEM_ACCESS_SUBWORD_EN
        size = 2'b00; wdata = 32'h0000_00EE;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
`else
        size = 2'b10; wdata = 32'h1234_5678;
        @(negedge clk);
        req = 1'b0;
`endif
        total++; if (ram_wr_en !== 1'b1) $display("FAIL rst_wr_pre: wr_en=%b, required 1", ram_wr_en); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (ram_wr_en !== 1'b0) $display("FAIL rst_wr_drop: wr_en=%b, required 0", ram_wr_en); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: busy=%b, required 0", busy); else passed++;
        @(negedge clk);
        total++; if (mem[8] !== 32'hCAFE_F00D) $display("FAIL rst_mem: word8=%h, required cafef00d", mem[8]); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done: done=%b, required 0", done); else passed++;
        reset = 1'b0;
        rd_model = 32'h0;
        late_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) late_done = 1;
        end
        total++; if (late_done != 0) $display("FAIL rst_late_done: done seen=%0d, required 0", late_done); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL rst_rdata: rdata=%h, required 0", rdata); else passed++;
        total++; if (mem[8] !== 32'hCAFE_F00D) $display("FAIL rst_mem_late: word8=%h, required cafef00d", mem[8]); else passed++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_mid_wr();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d outstanding, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Requester-side controller that drives the single-port data `ram`: synchronous write, combinational read.
- Sits between the multi-cycle MIPS state machine and the data memory.
- Converts a one-shot load/store request (byte, halfword or word; signed or unsigned) into RAM cycles.
- Sub-word stores use read-modify-write. The block returns read data with a done/error handshake.

## Interface
Parameters:
- `DEPTH`, 256, RAM depth in 32-bit words; must be a power of 2.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, RAM word-address width.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  1  request strobe; sampled only in IDLE.
- `we`  input  1  1 = store, 0 = load.
- `size`  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `signed_ld`  input  1  sign-extend sub-word loads.
- `byte_addr`  input  ADDR_WIDTH+2  byte address.
- `wdata`  input  32  store data, right-aligned.
- `busy`  output  1  high while FSM is not IDLE.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  one-cycle pulse with `done` on a misaligned or illegal request.
- `rdata`  output  32  load result; held until the next `done`.
- `ram_addr`  output  ADDR_WIDTH  word address to RAM.
- `ram_data_in`  output  32  write data to RAM.
- `ram_wr_en`  output  1  RAM write enable.
- `ram_data_out`  input  32  combinational RAM read data.

## Operation
- FSM states: IDLE, RD, WR.
- Accept: IDLE and `req` = 1. On accept, latch `we`, `size`, `signed_ld`, `byte_addr` and `wdata`. Later input changes are ignored until the next accept.
- `req` while `busy` is ignored; no queueing.
- Word address = `byte_addr[ADDR_WIDTH+1:2]`. Byte lane = `byte_addr[1:0]`.
- Little-endian lanes: lane 0 = bits [7:0]. A halfword at lane 2 = bits [31:16].
- Alignment check at accept:
  - halfword requires `byte_addr[0]` = 0;
  - word requires `byte_addr[1:0]` = 0;
  - `size` = 11 is always illegal.
- A failing request stays in IDLE and makes no RAM access; `done` and `err` pulse next cycle.
- Load: IDLE→RD. In RD, capture `ram_data_out`, then extract the lane and zero- or sign-extend into `rdata`. RD→IDLE.
- Word store: IDLE→WR. In WR, `ram_wr_en` = 1 and `ram_data_in` = `wdata`. WR→IDLE.
- Sub-word store: IDLE→RD (capture the old word into a hold register) →WR. WR writes the hold word with the selected lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`. WR→IDLE.
- `done` is a registered flag set on every transition into IDLE from RD/WR and on an error accept.
- A new request may be accepted in the same cycle `done` is high.
- `ram_wr_en` is decoded only from state WR; it is never high in IDLE or RD.
- `ram_addr` holds the latched word address.

## Timing
- Reset values: state IDLE; `busy` 0, `done` 0, `err` 0, `rdata` 0, `ram_addr` 0, `ram_data_in` 0, `ram_wr_en` 0.
- Accept at cycle T; `done` timing:
  - load: T+2;
  - word store: T+2, RAM written at the edge ending T+1;
  - sub-word store: T+3, RAM written at the edge ending T+2;
  - error: T+1.
- `busy` is high from T+1 until the `done` cycle, where it is 0.
- `rdata` updates in the `done` cycle of loads only. Stores and errors leave it unchanged.
- Reset mid-operation: FSM goes to IDLE immediately and `ram_wr_en` drops asynchronously. No RAM write occurs at the following edge and no `done` is issued.
- Back-to-back: throughput is one request per 2 cycles for loads and word stores, 3 cycles for sub-word stores.

## Configuration
- Macro: `MEM_ACCESS_SUBWORD_EN`.
- Defined: byte and halfword loads/stores are supported as described above.
- Undefined:
  - only `size` = 10 is legal; 00 and 01 produce an `err` pulse like 11;
  - RD is used only for loads and there is no hold register;
  - `signed_ld` is ignored.

## Test plan
- Reset with `req` = 1 held → all outputs 0. After release with `req` = 0, `busy` stays 0 and `ram_wr_en` never rises.
- sw 0xDEADBEEF @0x10 at T → `ram_wr_en` = 1 with `ram_addr` = 4 in T+1, `done` at T+2. Then lw @0x10 → `rdata` = 0xDEADBEEF with `done` 2 cycles after accept.
- Word 4 = 0x11223344; sb 0xA5 @0x11 → word 4 = 0x1122A544, `done` at T+3. lb signed @0x11 → 0xFFFFFFA5; unsigned → 0x000000A5.
- sh 0x8001 @0x12 over 0x1122A544 → word = 0x8001A544. lh signed @0x12 → 0xFFFF8001; lhu → 0x00008001.
- lw @0x13 and sh @0x11 → `done` and `err` at T+1, no `ram_wr_en`, `rdata` unchanged. With the macro undefined, sb @0x10 → `err` as well.
- sb in progress with reset asserted mid-WR (before the edge) → `ram_wr_en` drops at once, RAM word unchanged, `busy` 0, no `done`.
